// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port cache-line burst arbiter for single-ported main memory
module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_wnext,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        owner
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFF    = BEAT_W + 2;
  localparam int BASE_W = ADDR_W - OFF;

  // own / last_grant encoding: 0 = I port, 1 = D port
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic                own_q, own_d;
  logic                we_q, we_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_d_port;
  logic                last_beat;

  // Line-offset bits of the request addresses are deliberately ignored.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};

  // Read data is broadcast to both ports; only the valid strobes are steered.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));

  // State register with synchronous reset; reset abandons any burst in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      own_q        <= PORT_I;
      we_q         <= 1'b0;
      base_q       <= '0;
      beat_q       <= '0;
      last_grant_q <= PORT_I;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      we_q         <= we_d;
      base_q       <= base_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grant selection in IDLE, beat sequencing and same-cycle strobes in BURST.
  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    we_d         = we_q;
    base_d       = base_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    grant_d_port = PORT_I;

    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner     = 2'b00;
    i_rvalid  = 1'b0;
    i_done    = 1'b0;
    d_rvalid  = 1'b0;
    d_wnext   = 1'b0;
    d_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // A tie goes to whichever port did not win the previous grant.
          grant_d_port = d_req && (!i_req || (last_grant_q == PORT_I));
          own_d        = grant_d_port;
          we_d         = grant_d_port ? d_we : 1'b0;
          base_d       = grant_d_port ? d_addr[ADDR_W-1:OFF] : i_addr[ADDR_W-1:OFF];
          beat_d       = '0;
          last_grant_d = grant_d_port;
          state_d      = BURST;
        end
      end

      BURST: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {base_q, beat_q, 2'b00};
        mem_wdata = d_wdata;
        owner     = (own_q == PORT_D) ? 2'b10 : 2'b01;
        if (mem_ack) begin
          beat_d = beat_q + BEAT_W'(1);
          if (we_q) begin
            d_wnext = 1'b1;
          end else if (own_q == PORT_D) begin
            d_rvalid = 1'b1;
          end else begin
            i_rvalid = 1'b1;
          end
          if (last_beat) begin
            if (own_q == PORT_D) begin
              d_done = 1'b1;
            end else begin
              i_done = 1'b1;
            end
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported main memory between the instruction-cache refill port and the data-cache refill/write-back port of the pipelined CPU. Each requester asks for one whole cache line; the arbiter picks a winner, runs a burst of `LINE_WORDS` word beats against memory, and signals completion. Ties alternate between the two requesters so neither starves. The block sits between the two cache controllers and the memory bus.

## Interface

**Parameters**
- `LINE_WORDS`, default 4: words per line burst. Must be a power of two, at least 2.
- `ADDR_W`, default 32: byte-address width.

**Ports** (clock and reset first)
- `CLK` in 1: single clock. All state changes on the rising edge.
- `RESET` in 1: synchronous, active-high.
- `i_req` in 1: I-port line-read request. Held until `i_done`.
- `i_addr` in ADDR_W: I-port line address. Offset bits are ignored.
- `i_rdata` out 32: read beat data.
- `i_rvalid` out 1: I-port read beat valid.
- `i_done` out 1: I-port burst complete. One-cycle pulse.
- `d_req` in 1: D-port request. Held until `d_done`.
- `d_we` in 1: D-port direction. 1 = line write, 0 = line read.
- `d_addr` in ADDR_W: D-port line address.
- `d_wdata` in 32: write data for the current beat.
- `d_wnext` out 1: current write beat accepted. Requester advances to the next word.
- `d_rdata` out 32: read beat data.
- `d_rvalid` out 1: D-port read beat valid.
- `d_done` out 1: D-port burst complete. One-cycle pulse.
- `mem_req` out 1: memory beat request.
- `mem_we` out 1: memory beat direction.
- `mem_addr` out ADDR_W: memory beat byte address.
- `mem_wdata` out 32: memory beat write data.
- `mem_ack` in 1: beat accepted or completed. Read data is valid in the same cycle.
- `mem_rdata` in 32: memory read data.
- `owner` out 2: current grant. 00 = none, 01 = I, 10 = D.

## Operation

**State machine:** IDLE, BURST. Registered state holds `own` (I or D), `we`, `base`, `beat` (log2 `LINE_WORDS` bits) and `last_grant`.

**IDLE**
- `mem_req` = 0 and `owner` = 00.
- On a clock edge with a request present, latch the winner, its address and its direction, set `beat` = 0, and go to BURST.
- Only `i_req`: grant I. The I port always reads (`we` = 0).
- Only `d_req`: grant D with `we` = `d_we`.
- Both requests: grant the port that is not `last_grant`.
- Update `last_grant` on every grant.

**BURST**
- `mem_req` = 1 and `mem_we` = latched `we`.
- `mem_addr` = {`base`[ADDR_W-1 : log2(LINE_WORDS)+2], `beat`, 2'b00}.
- `mem_wdata` = `d_wdata` passed through combinationally.
- On `mem_ack`:
  - `beat` increments.
  - Read: assert the owner's `*_rvalid` in the same cycle, with `*_rdata` = `mem_rdata`.
  - Write: `d_wnext` = 1.
- On `mem_ack` with `beat` == `LINE_WORDS`-1:
  - Assert the owner's `*_done` in the same cycle.
  - `beat` wraps to 0 and the next state is IDLE.
- `i_rdata`/`d_rdata` always mirror `mem_rdata`. Only the valid strobes are gated.

**Protocol and boundary rules**
- Requester rules:
  - Address and `d_we` are sampled only at grant. Later changes are ignored.
  - The requester must deassert its request in the cycle after `*_done`, or it is re-granted as a new request.
- `mem_ack` while `mem_req` = 0 is ignored.
- Requests arriving during BURST wait. The request not granted stays pending and is not lost.
- `last_grant` alternation applies only to ties. A lone requester is granted on back-to-back bursts.
- Reset:
  - Forces IDLE, `beat` = 0, `last_grant` = I, so D wins the first tie.
  - Reset mid-burst abandons the burst with no `*_done`.
  - A request still held after reset restarts at beat 0.

## Timing

**Reset values:** every output is 0, including `owner` = 00. `*_rdata` follow `mem_rdata`.

**Grant latency:** a request is sampled at edge k, and `mem_req` goes high in the cycle after edge k.

**Burst length:** `LINE_WORDS` acked cycles. With `mem_ack` every cycle, a burst occupies `LINE_WORDS` cycles plus one IDLE cycle before the next grant.

**Same-cycle outputs:** `*_rvalid`, `d_wnext` and `*_done` are combinational with `mem_ack`, in the same cycle.

**Memory hold rule:** `mem_addr`/`mem_we` are stable while `mem_req` is high and unacked.

## Test plan

1. **Lone I read.** `i_req` with `i_addr` = 0x1234, ack every cycle, `mem_rdata` = 0xA0..0xA3 → `mem_addr` = 0x1230, 0x1234, 0x1238, 0x123C; `i_rvalid` ×4 with matching data; `i_done` on the 4th beat; `owner` = 01 then 00.
2. **D write with stalled acks.** `d_we` = 1, `d_addr` = 0x2000, `mem_ack` every third cycle → `mem_addr` holds each beat until ack; `d_wnext` ×4, each coincident with an ack; `mem_wdata` tracks `d_wdata`; `d_done` with the last ack.
3. **Simultaneous requests after reset.** Both requests raised → D is granted first, I second. Both raised again → D first again, because `last_grant` = I after the I burst.
4. **Continuous contention.** Both requests held for 6 bursts → grants strictly alternate; neither port waits more than one burst.
5. **Reset mid-burst.** Pulse `RESET` after 2 of 4 beats → next cycle `mem_req` = 0, no `*_done`; with `i_req` held, the burst restarts at `beat` 0 with `mem_addr` = base.
6. **Stray ack and re-request.** `mem_ack` in IDLE → no strobes. Holding `i_req` in the cycle after `i_done` → second I grant and a second 4-beat burst.
